axis_mux_n: RTL and testbench
=============================

AXIS_MUX_N -- requirements
Module: axis_mux_n

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning tdata width per channel in bits (1..64).
REQ-002 SHALL have parameter NUM_CH, default 4, meaning number of slave channels (2..16); SEL_W = max(1, clog2(NUM_CH)) is derived, not a parameter.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sel  input  SEL_W  requested channel index.
REQ-006 SHALL have port s_tdata  input  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].
REQ-007 SHALL have ports s_tvalid and s_tlast  input  NUM_CH  one bit per channel.
REQ-008 SHALL have port s_tready  output  NUM_CH  one bit per channel.
REQ-009 SHALL have port m_tdata  output  DATA_W  registered output data.
REQ-010 SHALL have ports m_tvalid and m_tlast  output  1  registered master valid and last.
REQ-011 SHALL have port m_tready  input  1  master backpressure.
REQ-012 SHALL have port busy  output  1  high while in state LOCKED.
REQ-013 SHALL have port active_ch  output  SEL_W  channel currently granted (lock_ch in LOCKED, sel in IDLE).

Function
REQ-014 SHALL implement FSM states IDLE and LOCKED.
REQ-015 IDLE: granted channel = sel, sampled combinationally every cycle.
REQ-016 IDLE: an accepted beat with tlast=0 SHALL move to LOCKED and capture lock_ch = sel; an accepted beat with tlast=1 (single-beat packet) SHALL stay in IDLE.
REQ-017 LOCKED: sel SHALL be ignored; granted channel = lock_ch; an accepted beat with tlast=1 SHALL return to IDLE next cycle.
REQ-018 A beat is accepted when s_tvalid[g] and s_tready[g] are both high, where g is the granted channel.
REQ-019 s_tready[c] SHALL be 0 for every c other than g, regardless of s_tvalid.
REQ-020 sel >= NUM_CH in IDLE SHALL grant no channel: all s_tready=0, no state change.
REQ-021 Accepted beats SHALL appear on m_tdata/m_tlast with m_tvalid=1 exactly 1 cycle after acceptance when the output register is empty or draining.
REQ-022 The output register SHALL hold m_tdata/m_tlast/m_tvalid stable while m_tvalid=1 and m_tready=0.
REQ-023 Beat order SHALL be preserved; no beat SHALL be dropped or duplicated.
REQ-024 Back-to-back packets from different channels SHALL sustain 1 beat/cycle when m_tready=1; the switch takes effect on the cycle after the tlast beat is accepted.

Reset
REQ-025 On reset: m_tvalid=0, m_tlast=0, m_tdata=0, state=IDLE, busy=0, lock_ch=0, skid buffer empty, s_tready=0 while reset is high.
REQ-026 Reset mid-packet SHALL discard the partial packet and any buffered beats; after reset release, arbitration SHALL restart in IDLE with no residual lock.

Configuration
REQ-027 Macro AXIS_MUX_SKID_EN SHALL select the ready path.
REQ-028 Without AXIS_MUX_SKID_EN: s_tready[g] = !m_tvalid || m_tready, a combinational path from m_tready.
REQ-029 With AXIS_MUX_SKID_EN: s_tready SHALL be driven from a register (high when the one-entry skid buffer is empty). A beat accepted while the output register is stalled SHALL be stored in the skid buffer and presented on the output before any later beat. Throughput and the latency of REQ-021 SHALL be unchanged when the master is not stalled.

Verification
REQ-030 Single-beat packet: NUM_CH=4, sel=2, s_tvalid[2]=1, tlast=1, tdata=0xA5, m_tready=1 -> m_tdata=0xA5, m_tlast=1, m_tvalid=1 one cycle later; busy stays 0.
REQ-031 Packet lock: 3-beat packet on ch1 (0x11,0x12,0x13); sel changes to 3 after the first beat -> all three beats output from ch1, busy=1 until the 0x13 accept, then ch3 is granted.
REQ-032 Backpressure: m_tready=0 for 3 cycles mid-packet -> m_tdata held stable; s_tready[g]=0 (in skid build, after at most one extra buffered beat); no loss after m_tready=1.
REQ-033 Out-of-range sel: NUM_CH=3, sel=3 with all channels valid -> s_tready=000, m_tvalid stays 0.
REQ-034 Reset mid-packet: assert reset after beat 2 of a 4-beat ch0 packet -> m_tvalid=0 immediately; busy=0; a subsequent ch2 packet passes intact.
REQ-035 Both builds (with and without AXIS_MUX_SKID_EN) SHALL pass REQ-030..REQ-034 with a randomised m_tready, checked against a scoreboard.

Source files
------------

// File: rtl/axis_mux_n.sv
// N-to-1 AXI-Stream mux with packet lock: a channel selected in IDLE keeps the
// grant until its tlast beat. Define AXIS_MUX_SKID_EN for a registered s_tready with a one-entry skid buffer.
module axis_mux_n #(
    parameter int DATA_W = 8,
    parameter int NUM_CH = 4,
    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] s_tdata,
    input  logic [NUM_CH-1:0]        s_tvalid,
    input  logic [NUM_CH-1:0]        s_tlast,
    output logic [NUM_CH-1:0]        s_tready,
    output logic [DATA_W-1:0]        m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic                     busy,
    output logic [SEL_W-1:0]         active_ch
);

    typedef enum logic {IDLE, LOCKED} state_t;

    localparam logic [SEL_W:0] NUM_CH_L = (SEL_W+1)'(NUM_CH);

    state_t             state_q;
    logic [SEL_W-1:0]   lock_ch_q;
    logic               busy_q;
    logic [DATA_W-1:0]  m_tdata_q;
    logic               m_tvalid_q;
    logic               m_tlast_q;

    logic [SEL_W-1:0]   gnt_ch;
    logic               gnt_ok;
    logic [NUM_CH-1:0]  gnt_oh;
    logic [DATA_W-1:0]  in_data;
    logic               in_last;
    logic               rdy;
    logic               acc;

    assign gnt_ch = (state_q == LOCKED) ? lock_ch_q : sel;
    // An out-of-range sel in IDLE grants nobody.
    assign gnt_ok = (state_q == LOCKED) || ({1'b0, sel} < NUM_CH_L);

    always_comb begin
        gnt_oh  = '0;
        in_data = '0;
        in_last = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (gnt_ok && (gnt_ch == SEL_W'(c))) gnt_oh[c] = 1'b1;
            in_data = in_data | (s_tdata[c*DATA_W +: DATA_W] & {DATA_W{gnt_oh[c]}});
            in_last = in_last | (s_tlast[c] & gnt_oh[c]);
        end
    end

`ifdef AXIS_MUX_SKID_EN
    logic [DATA_W-1:0] skid_data_q;
    logic              skid_last_q;
    logic              skid_vld_q;
    logic              out_free;

    assign rdy      = !skid_vld_q && !reset;
    assign out_free = !m_tvalid_q || m_tready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            skid_data_q <= '0;
            skid_last_q <= 1'b0;
            skid_vld_q  <= 1'b0;
        end else if (out_free) begin
            // Skid beat is older than anything arriving now, so it goes first.
            if (skid_vld_q) begin
                m_tdata_q  <= skid_data_q;
                m_tlast_q  <= skid_last_q;
                m_tvalid_q <= 1'b1;
                skid_vld_q <= 1'b0;
            end else if (acc) begin
                m_tdata_q  <= in_data;
                m_tlast_q  <= in_last;
                m_tvalid_q <= 1'b1;
            end else begin
                m_tvalid_q <= 1'b0;
            end
        end else if (acc) begin
            skid_data_q <= in_data;
            skid_last_q <= in_last;
            skid_vld_q  <= 1'b1;
        end
    end
`else
    assign rdy = (!m_tvalid_q || m_tready) && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
        end else if (acc) begin
            m_tdata_q  <= in_data;
            m_tlast_q  <= in_last;
            m_tvalid_q <= 1'b1;
        end else if (m_tready) begin
            m_tvalid_q <= 1'b0;
        end
    end
`endif

    assign s_tready = gnt_oh & {NUM_CH{rdy}};
    assign acc      = |(s_tvalid & s_tready);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            lock_ch_q <= '0;
            busy_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            // Single-beat packets never lock.
            if (acc && !in_last) begin
                state_q   <= LOCKED;
                lock_ch_q <= sel;
                busy_q    <= 1'b1;
            end
        end else begin
            if (acc && in_last) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
        end
    end

    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign busy      = busy_q;
    assign active_ch = gnt_ch;

endmodule

// File: tb/tb_axis_mux_n.sv
// Scoreboard bench for axis_mux_n: directed packets with randomised m_tready,
// plus a 3-channel instance for out-of-range sel.
module tb_axis_mux_n;

    logic        clk, reset;
    logic [1:0]  sel;
    logic [31:0] s_tdata;
    logic [3:0]  s_tvalid, s_tlast, s_tready;
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tlast, m_tready, busy;
    logic [1:0]  active_ch;

    logic [1:0]  sel3;
    logic [23:0] s_tdata3;
    logic [2:0]  s_tvalid3, s_tlast3, s_tready3;
    logic [7:0]  m_tdata3;
    logic        m_tvalid3, m_tlast3, m_tready3, busy3;
    logic [1:0]  active_ch3;

    int checks = 0;
    int failures = 0;
    bit rand_en = 0;
    logic [8:0] sb[$];

`ifdef AXIS_MUX_SKID_EN
    localparam int STALL_EXP = 1;
`else
    localparam int STALL_EXP = 0;
`endif

    axis_mux_n #(.DATA_W(8), .NUM_CH(4)) u_dut (
        .clk(clk), .reset(reset), .sel(sel), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
        .s_tlast(s_tlast), .s_tready(s_tready), .m_tdata(m_tdata), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready), .busy(busy), .active_ch(active_ch)
    );

    axis_mux_n #(.DATA_W(8), .NUM_CH(3)) u_dut3 (
        .clk(clk), .reset(reset), .sel(sel3), .s_tdata(s_tdata3), .s_tvalid(s_tvalid3),
        .s_tlast(s_tlast3), .s_tready(s_tready3), .m_tdata(m_tdata3), .m_tvalid(m_tvalid3),
        .m_tlast(m_tlast3), .m_tready(m_tready3), .busy(busy3), .active_ch(active_ch3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_en) m_tready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output handshake pops one expected beat.
    always @(negedge clk) begin
        if (!reset && m_tvalid && m_tready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_beat", {m_tlast, m_tdata}, 9'h1ff);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                chk("sb_beat", {m_tlast, m_tdata}, e);
            end
        end
    end

    task automatic set_ch(input int ch, input logic [7:0] d, input logic last);
        s_tvalid[ch] = 1'b1;
        s_tdata[ch*8 +: 8] = d;
        s_tlast[ch] = last;
    endtask

    // Waits for the already-presented beat on ch to be accepted; returns at posedge+1.
    task automatic wait_accept(input int ch, input logic [7:0] d, input logic last, output int waited);
        bit ok = 0;
        waited = 0;
        while (!ok && waited < 200) begin
            @(negedge clk);
            waited++;
            if (s_tready[ch] && s_tvalid[ch]) begin
                sb.push_back({last, d});
                ok = 1;
            end
        end
        @(posedge clk);
        #1;
        s_tvalid[ch] = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic send_beat(input int ch, input logic [7:0] d, input logic last);
        int w;
        set_ch(ch, d, last);
        wait_accept(ch, d, last, w);
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || m_tvalid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", sb.size(), 0);
    endtask

    initial begin
        logic [7:0] bp [4];
        int k, stall_acc, w;

        reset = 1'b1; sel = 2'd0; s_tdata = '0; s_tvalid = 4'hF; s_tlast = '0; m_tready = 1'b1;
        sel3 = 2'd3; s_tdata3 = 24'h332211; s_tvalid3 = 3'b111; s_tlast3 = 3'b111; m_tready3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_busy", busy, 0);
        chk("rst_s_tready", s_tready, 4'h0);
        s_tvalid = 4'h0;
        reset = 1'b0;

        // Out-of-range sel on the 3-channel instance.
        repeat (3) begin
            @(negedge clk);
            chk("oor_s_tready", s_tready3, 3'b000);
            chk("oor_m_tvalid", m_tvalid3, 0);
            chk("oor_busy", busy3, 0);
        end

        // Single-beat packet, fixed ready to observe latency.
        @(posedge clk); #1;
        sel = 2'd2;
        send_beat(2, 8'hA5, 1'b1);
        chk("single_m_tvalid", m_tvalid, 1);
        chk("single_m_tdata", m_tdata, 8'hA5);
        chk("single_m_tlast", m_tlast, 1);
        chk("single_busy", busy, 0);
        drain();

        // Back-to-back single-beat packets from different channels.
        sel = 2'd0;
        s_tvalid[1] = 1'b1; s_tdata[15:8] = 8'h61; s_tlast[1] = 1'b1;
        send_beat(0, 8'h51, 1'b1);
        sel = 2'd1;
        wait_accept(1, 8'h61, 1'b1, w);
        chk("b2b_gap_cycles", w, 1);
        drain();

        // Packet lock: ch3 is valid throughout but must wait for ch1's tlast.
        rand_en = 1;
        sel = 2'd1;
        set_ch(3, 8'h33, 1'b1);
        send_beat(1, 8'h11, 1'b0);
        sel = 2'd3;
        chk("lock_busy1", busy, 1);
        chk("lock_active1", active_ch, 2'd1);
        send_beat(1, 8'h12, 1'b0);
        chk("lock_busy2", busy, 1);
        chk("lock_active2", active_ch, 2'd1);
        send_beat(1, 8'h13, 1'b1);
        chk("lock_busy_end", busy, 0);
        chk("lock_active_ch3", active_ch, 2'd3);
        wait_accept(3, 8'h33, 1'b1, w);
        drain();

        // Backpressure mid-packet on ch0.
        rand_en = 0; m_tready = 1'b1; sel = 2'd0;
        bp[0] = 8'h21; bp[1] = 8'h22; bp[2] = 8'h23; bp[3] = 8'h24;
        send_beat(0, bp[0], 1'b0);
        m_tready = 1'b0;
        k = 1; stall_acc = 0;
        set_ch(0, bp[k], 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_valid", m_tvalid, 1);
            chk("bp_hold_data", m_tdata, bp[0]);
            if (s_tready[0]) begin
                sb.push_back({1'b0, bp[k]});
                k++;
                stall_acc++;
            end
            @(posedge clk); #1;
            set_ch(0, bp[k], k == 3);
        end
        chk("bp_stall_accepts", stall_acc, STALL_EXP);
        rand_en = 1;
        while (k < 4) begin
            wait_accept(0, bp[k], k == 3, w);
            k++;
            if (k < 4) set_ch(0, bp[k], k == 3);
        end
        drain();

        // Reset mid-packet, then a clean ch2 packet.
        sel = 2'd0;
        send_beat(0, 8'h31, 1'b0);
        send_beat(0, 8'h32, 1'b0);
        set_ch(0, 8'h33, 1'b0);
        reset = 1'b1;
        sb.delete();
        #1;
        chk("rmid_m_tvalid", m_tvalid, 0);
        chk("rmid_busy", busy, 0);
        chk("rmid_s_tready", s_tready, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        s_tvalid = 4'h0;
        reset = 1'b0;
        sel = 2'd2;
        #1;
        chk("rpost_active", active_ch, 2'd2);
        chk("rpost_busy", busy, 0);
        send_beat(2, 8'h41, 1'b0);
        chk("rpost_busy_lock", busy, 1);
        send_beat(2, 8'h42, 1'b0);
        send_beat(2, 8'h43, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
